fp_alu_host_driver: RTL
=======================

// Module: fp_alu_host_driver
// PURPOSE
//   Host-side initiator for the byte-serial 32-bit FP ALU pin interface.
//   Accepts one 32-bit operand pair + opcode per request on a valid/ready port and pulses start.
//   Serialises the operands onto the 8-bit ALU input bus, waits for done and collects the 4 result bytes.
//   Returns the reassembled 32-bit result on a valid/ready response port.
//   Sits in the test harness / FPGA wrapper, driving the ALU's ui_in/uio_in and reading its uo_out/uio_out.
// PARAMETERS
//   TIMEOUT_CYCLES  1024  max cycles in WAIT without alu_done before aborting (>=1)
// PORTS
//   clk           in   1   system clock, all logic on rising edge
//   rst           in   1   asynchronous reset, active-high
//   req_valid     in   1   request present
//   req_ready     out  1   driver can accept request (high only in IDLE)
//   req_opcode    in   2   ALU operation select
//   req_a         in   32  operand A (IEEE-754 single)
//   req_b         in   32  operand B (IEEE-754 single)
//   rsp_valid     out  1   response present; held until rsp_ready
//   rsp_ready     in   1   consumer accepts response
//   rsp_result    out  32  reassembled ALU result (0 on timeout)
//   rsp_timeout   out  1   response produced by timeout, not by alu_done
//   rsp_state     out  4   alu_state sampled on first alu_done cycle (0 on timeout)
//   busy          out  1   high in every state except IDLE
//   alu_in        out  8   operand byte to ALU
//   alu_opcode    out  2   opcode to ALU; held stable from START through RECV
//   alu_start     out  1   one-cycle start pulse
//   alu_out       in   8   result byte from ALU
//   alu_done      in   1   ALU result-ready flag
//   alu_state     in   4   ALU state (debug)
// BEHAVIOUR
//   Reset: all outputs 0 except req_ready=1; state IDLE; counters 0. Reset mid-operation aborts
//     immediately; alu_start drops the same instant; no response is produced.
//   States: IDLE -> START -> SEND -> WAIT -> RECV -> RESP -> IDLE.
//   IDLE: req_ready=1. On req_valid&req_ready, latch a/b/opcode and go to START.
//   START (1 cycle): alu_start=1, alu_opcode=latched opcode, alu_in=0.
//   SEND (8 cycles, byte counter 0..7): alu_in = A[7:0],A[15:8],A[23:16],A[31:24],
//     then B[7:0]..B[31:24]. LSB first. alu_start=0. alu_done ignored here.
//   WAIT: alu_in=0; timeout counter increments each cycle.
//     - alu_done=1: capture alu_out into result[7:0], alu_state into rsp_state; go to RECV.
//     - counter reaches TIMEOUT_CYCLES with no done: result=0, rsp_timeout=1; go to RESP.
//     - done and timeout in the same cycle: done wins.
//   RECV (3 cycles): capture alu_out into result[15:8], [23:16], [31:24] on successive cycles,
//     regardless of alu_done level; then go to RESP.
//   RESP: rsp_valid=1, rsp_result/rsp_timeout/rsp_state stable; on rsp_ready go to IDLE.
//     Fields clear when leaving RESP.
//   Latency: request accepted at edge T.
//     - alu_start high in cycle T+1; operand bytes in cycles T+2..T+9; WAIT from T+10.
//     - If first done in cycle D: result bytes sampled in D..D+3; rsp_valid high from D+4.
//   Throughput: at most one outstanding request; req_ready low while busy.
//     RESP -> IDLE costs one bubble cycle.
//   Byte/counter widths: byte counter 3 bits; timeout counter $clog2(TIMEOUT_CYCLES+1) bits,
//     saturating, cleared on entry to WAIT.
// TESTING
//   1. Reset asserted mid-SEND -> all outputs reset values that cycle;
//      after release req_ready=1, no rsp_valid.
//   2. req_a=0x3F800000, req_b=0x40000000, opcode=0; model returns done 5 cycles after the
//      last byte with bytes 00,00,40,40 ->
//      - alu_start pulses once; alu_in = 00,00,80,3F,00,00,00,40;
//      - rsp_result=0x40400000, rsp_timeout=0.
//   3. TIMEOUT_CYCLES=16, ALU model never asserts done -> rsp_valid exactly 16 cycles after
//      WAIT entry, rsp_result=0, rsp_timeout=1.
//   4. rsp_ready held low 10 cycles -> rsp_valid/rsp_result stable, req_ready=0 throughout;
//      new req accepted on the cycle after the rsp handshake.
//   5. alu_done pulsed during SEND, then asserted for 1 cycle only in WAIT ->
//      SEND unaffected; all 4 bytes still captured from consecutive cycles.
//   6. Back-to-back requests with opcodes 1,2,3 -> alu_opcode matches each request and
//      stays stable START..RECV; three correct responses in order.

Source files
------------

// File: rtl/fp_alu_host_driver_if.sv
// rtl/fp_alu_host_driver_if.sv - request/response and ALU pin bundle for the FP ALU host driver
interface fp_alu_host_driver_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_timeout;
    logic [3:0]  rsp_state;
    logic        busy;

    logic [7:0]  alu_in;
    logic [1:0]  alu_opcode;
    logic        alu_start;
    logic [7:0]  alu_out;
    logic        alu_done;
    logic [3:0]  alu_state;

    modport master (
        input  req_valid, req_opcode, req_a, req_b,
        input  rsp_ready,
        input  alu_out, alu_done, alu_state,
        output req_ready,
        output rsp_valid, rsp_result, rsp_timeout, rsp_state, busy,
        output alu_in, alu_opcode, alu_start
    );

    modport slave (
        output req_valid, req_opcode, req_a, req_b,
        output rsp_ready,
        output alu_out, alu_done, alu_state,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_timeout, rsp_state, busy,
        input  alu_in, alu_opcode, alu_start
    );
endinterface

// File: rtl/fp_alu_host_driver.sv
// rtl/fp_alu_host_driver.sv - host initiator serialising operands to the byte-wide FP ALU and collecting its result
module fp_alu_host_driver #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_alu_host_driver_if.master  bus
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_SAT  = {TW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_RECV  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_opcode;
    logic [31:0] r_result;
    logic        r_timeout;
    logic [3:0]  r_rsp_state;
    logic [2:0]  r_byte_cnt;
    logic [TW-1:0] r_tmo_cnt;

    logic [63:0] w_operands;
    logic [1:0]  w_recv_idx;
    logic        w_last_byte;
    logic        w_last_recv;
    logic        w_tmo_hit;

    assign w_operands  = {r_b, r_a};
    assign w_recv_idx  = r_byte_cnt[1:0] + 2'd1;
    assign w_last_byte = (r_byte_cnt == 3'd7);
    assign w_last_recv = (r_byte_cnt == 3'd2);
    // The last WAIT cycle is the one whose count is TIMEOUT_CYCLES-1, so RESP
    // lands exactly TIMEOUT_CYCLES cycles after WAIT entry.
    assign w_tmo_hit   = (r_tmo_cnt >= TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.req_ready   = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_result  = 32'd0;
        bus.rsp_timeout = 1'b0;
        bus.rsp_state   = 4'd0;
        bus.busy        = (r_state != S_IDLE);
        bus.alu_in      = 8'd0;
        bus.alu_opcode  = 2'd0;
        bus.alu_start   = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                bus.alu_start  = 1'b1;
                bus.alu_opcode = r_opcode;
                w_next         = S_SEND;
            end
            S_SEND: begin
                bus.alu_opcode = r_opcode;
                bus.alu_in     = w_operands[{r_byte_cnt, 3'b000} +: 8];
                if (w_last_byte) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                bus.alu_opcode = r_opcode;
                if (bus.alu_done) begin
                    w_next = S_RECV;
                end else if (w_tmo_hit) begin
                    w_next = S_RESP;
                end
            end
            S_RECV: begin
                bus.alu_opcode = r_opcode;
                if (w_last_recv) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                bus.rsp_valid   = 1'b1;
                bus.rsp_result  = r_result;
                bus.rsp_timeout = r_timeout;
                bus.rsp_state   = r_rsp_state;
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_opcode    <= 2'd0;
            r_result    <= 32'd0;
            r_timeout   <= 1'b0;
            r_rsp_state <= 4'd0;
            r_byte_cnt  <= 3'd0;
            r_tmo_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_a      <= bus.req_a;
                        r_b      <= bus.req_b;
                        r_opcode <= bus.req_opcode;
                    end
                end
                S_START: begin
                    r_byte_cnt <= 3'd0;
                end
                S_SEND: begin
                    // Wraps 7 -> 0, leaving the counter ready for RECV.
                    r_byte_cnt <= r_byte_cnt + 3'd1;
                    if (w_last_byte) begin
                        r_tmo_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (r_tmo_cnt != TMO_SAT) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                    if (bus.alu_done) begin
                        r_result    <= {24'd0, bus.alu_out};
                        r_rsp_state <= bus.alu_state;
                        r_byte_cnt  <= 3'd0;
                    end else if (w_tmo_hit) begin
                        r_result  <= 32'd0;
                        r_timeout <= 1'b1;
                    end
                end
                S_RECV: begin
                    r_result[{w_recv_idx, 3'b000} +: 8] <= bus.alu_out;
                    r_byte_cnt <= r_byte_cnt + 3'd1;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_result    <= 32'd0;
                        r_timeout   <= 1'b0;
                        r_rsp_state <= 4'd0;
                        r_opcode    <= 2'd0;
                    end
                end
                default: begin
                    r_byte_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule
